// File: rtl/cfd_pkg.sv
// cfd_pkg: shared FSM encoding and helper functions for the CFD self-trigger
package cfd_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLDOFF} state_e;

    function automatic int dly_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int clamp_frac(input int num, input int frac_w);
        return (num > (1 << frac_w)) ? (1 << frac_w) : num;
    endfunction
endpackage

// File: rtl/cfd_selftrigger_multimode_delay_line.sv
// cfd_delay_line: circular-buffer delay of the input register, synchronous read
module cfd_delay_line
    import cfd_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_DELAY = 32,
    localparam int DLY_W    = dly_width(MAX_DELAY)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic [DLY_W-1:0]         delay_i,
    output logic signed [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0]    mem_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] vld_q;
    logic [DLY_W-1:0]     wr_ptr_q;
    logic [DLY_W-1:0]     rd_addr;
    logic [DATA_W-1:0]    rd_q;

    // din_i is the value in_reg takes on this edge, so reading before the write lines up delay=N
    assign rd_addr = wr_ptr_q - ((delay_i == '0) ? DLY_W'(1) : delay_i);
    assign dout_o  = rd_q;

    always_ff @(posedge clk_i)
        if (enable_i) mem_q[wr_ptr_q] <= din_i;

    // per-entry valid bits make never-written slots read as zero after reset
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            wr_ptr_q <= '0;
            vld_q    <= '0;
            rd_q     <= '0;
        end else if (enable_i) begin
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            vld_q[wr_ptr_q] <= 1'b1;
            rd_q            <= vld_q[rd_addr] ? mem_q[rd_addr] : '0;
        end
endmodule

// File: rtl/cfd_selftrigger_multimode.sv
// cfd_selftrigger_multimode: programmable constant-fraction self-trigger with zero-crossing capture
module cfd_selftrigger_multimode
    import cfd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MAX_DELAY   = 32,
    parameter int FRAC_W      = 4,
    parameter int ARM_TIMEOUT = 128,
    parameter int HOLD_W      = 16,
    parameter int CNT_W       = 16,
    localparam int DLY_W      = dly_width(MAX_DELAY)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] threshold_i,
    input  logic                     polarity_i,
    input  logic [DLY_W-1:0]         delay_i,
    input  logic [FRAC_W:0]          frac_num_i,
    input  logic [HOLD_W-1:0]        holdoff_i,
    output logic                     trigger_o,
    output logic signed [DATA_W:0]   y_o,
    output logic signed [DATA_W:0]   zc_pre_o,
    output logic signed [DATA_W:0]   zc_post_o,
    output logic                     armed_o,
    output logic [CNT_W-1:0]         trig_count_o,
    output logic [CNT_W-1:0]         timeout_count_o
);
    localparam int ARM_W = dly_width(ARM_TIMEOUT);

    state_e                     state_q, state_d;
    logic signed [DATA_W-1:0]   in_q, dly;
    logic signed [DATA_W:0]     y1_q, y1_d, y2_q;
    logic signed [DATA_W:0]     zc_pre_q, zc_pre_d, zc_post_q, zc_post_d;
    logic [ARM_W-1:0]           arm_cnt_q, arm_cnt_d;
    logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]           trig_cnt_q, trig_cnt_d, to_cnt_q, to_cnt_d;
    logic [FRAC_W:0]            frac_c;
    logic signed [DATA_W+FRAC_W+1:0] prod, prod_sh;
    logic signed [DATA_W:0]     in_x, th_x, scaled;
    logic                       th, xc;

    cfd_delay_line #(.DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY)) u_dly (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .din_i(x_i), .delay_i(delay_i), .dout_o(dly)
    );

    assign frac_c  = (FRAC_W+1)'(clamp_frac(int'(frac_num_i), FRAC_W));
    assign prod    = in_q * $signed({1'b0, frac_c});
    assign prod_sh = prod >>> FRAC_W;
    assign scaled  = prod_sh[DATA_W:0];
    assign y1_d    = scaled - (DATA_W+1)'(dly);
    assign in_x    = (DATA_W+1)'(in_q);
    assign th_x    = (DATA_W+1)'(threshold_i);
    assign th      = polarity_i ? (in_x > th_x) : (in_x < -th_x);
    // sign-bit tests: negative-going needs y_2<0 & y_1>=0, positive-going y_2>0 & y_1<=0
    assign xc      = polarity_i ? (!y2_q[DATA_W] && y2_q != '0 && (y1_q[DATA_W] || y1_q == '0))
                                : (y2_q[DATA_W] && !y1_q[DATA_W]);

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        hold_cnt_d = hold_cnt_q;
        trig_cnt_d = trig_cnt_q;
        to_cnt_d   = to_cnt_q;
        zc_pre_d   = zc_pre_q;
        zc_post_d  = zc_post_q;
        case (state_q)
            IDLE: if (enable_i && th) begin
                state_d   = ARMED;
                arm_cnt_d = '0;
            end
            ARMED: if (enable_i) begin
                if (xc) begin
                    state_d    = FIRE;
                    zc_pre_d   = y2_q;
                    zc_post_d  = y1_q;
                    trig_cnt_d = (&trig_cnt_q) ? trig_cnt_q : trig_cnt_q + 1'b1;
                    hold_cnt_d = holdoff_i;
                end else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT-1)) begin
                    state_d  = IDLE;
                    to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            FIRE: state_d = (hold_cnt_q == '0) ? IDLE : HOLDOFF;
            HOLDOFF: begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                state_d    = (hold_cnt_q == HOLD_W'(1)) ? IDLE : HOLDOFF;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q    <= IDLE;
            in_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            zc_pre_q   <= '0;
            zc_post_q  <= '0;
            arm_cnt_q  <= '0;
            hold_cnt_q <= '0;
            trig_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            zc_pre_q   <= zc_pre_d;
            zc_post_q  <= zc_post_d;
            arm_cnt_q  <= arm_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            trig_cnt_q <= trig_cnt_d;
            to_cnt_q   <= to_cnt_d;
            if (enable_i) begin
                in_q <= x_i;
                y1_q <= y1_d;
                y2_q <= y1_q;
            end
        end

    assign trigger_o       = (state_q == FIRE);
    assign armed_o         = (state_q == ARMED);
    assign y_o             = y1_q;
    assign zc_pre_o        = zc_pre_q;
    assign zc_post_o       = zc_post_q;
    assign trig_count_o    = trig_cnt_q;
    assign timeout_count_o = to_cnt_q;
endmodule

// File: tb/tb_cfd_selftrigger_multimode.sv
// tb_cfd_selftrigger_multimode: directed and randomized checks against a behavioural CFD model
module tb_cfd_selftrigger_multimode;
    logic clk = 0, reset = 1, enable = 0, polarity = 0;
    logic signed [15:0] x = 0, threshold = 0;
    logic [4:0] delay = 0, frac_num = 0;
    logic [15:0] holdoff = 0;
    logic trigger, armed;
    logic signed [16:0] y, zc_pre, zc_post;
    logic [15:0] trig_count, timeout_count;

    int nvec = 0, nerr = 0;
    int m_in, m_y1, m_y2, m_zp, m_zn, m_tc, m_to, m_mode, m_left, m_hold;
    int s[$];
    int ntrig, narm, ndis;
    int yq[$];
    bit toggle = 0;
    logic [84:0] first_got, first_want;
    logic [84:0] act_vec;

    always #5 clk = ~clk;

    cfd_selftrigger_multimode dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .x_i(x), .threshold_i(threshold),
        .polarity_i(polarity), .delay_i(delay), .frac_num_i(frac_num), .holdoff_i(holdoff),
        .trigger_o(trigger), .y_o(y), .zc_pre_o(zc_pre), .zc_post_o(zc_post), .armed_o(armed),
        .trig_count_o(trig_count), .timeout_count_o(timeout_count)
    );

    assign act_vec = {trigger, armed, y, zc_pre, zc_post, trig_count, timeout_count};

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [84:0] exp_vec();
        return {m_mode == 2, m_mode == 1, 17'(m_y1), 17'(m_zp), 17'(m_zn), 16'(m_tc), 16'(m_to)};
    endfunction

    task automatic mreset();
        m_in = 0; m_y1 = 0; m_y2 = 0; m_zp = 0; m_zn = 0; m_tc = 0; m_to = 0;
        m_mode = 0; m_left = 0; m_hold = 0;
        s.delete();
    endtask

    // Model: sample history queue gives the delayed term directly; mode 0..3 = idle/armed/fire/holdoff
    task automatic model_step();
        int f, n, d, k;
        bit th, xc;
        if (reset) begin
            mreset();
            return;
        end
        f  = (int'(frac_num) > 16) ? 16 : int'(frac_num);
        n  = (delay == 0) ? 1 : int'(delay);
        th = polarity ? (m_in > int'(threshold)) : (m_in < -int'(threshold));
        xc = polarity ? (m_y2 > 0 && m_y1 <= 0) : (m_y2 < 0 && m_y1 >= 0);
        case (m_mode)
            0: if (enable && th) begin m_mode = 1; m_left = 128; end
            1: if (enable) begin
                if (xc) begin
                    m_mode = 2; m_zp = m_y2; m_zn = m_y1; m_tc = sat(m_tc + 1); m_hold = int'(holdoff);
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_to = sat(m_to + 1); end
                end
            end
            2: m_mode = (m_hold == 0) ? 0 : 3;
            3: begin if (m_hold == 1) m_mode = 0; m_hold--; end
            default: ;
        endcase
        if (enable) begin
            k = s.size();
            d = (k - 1 - n >= 0) ? s[k-1-n] : 0;
            m_y2 = m_y1;
            m_y1 = ((m_in * f) >>> 4) - d;
            m_in = int'(x);
            s.push_back(m_in);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic config_dut(input bit pol, input int th, input int dl, input int fr, input int ho);
        polarity = pol; threshold = 16'(th); delay = 5'(dl); frac_num = 5'(fr); holdoff = 16'(ho);
        enable = 1; toggle = 0;
    endtask

    task automatic do_reset();
        reset = 1; x = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic clear_stats();
        ntrig = 0; narm = 0; ndis = 0; yq.delete();
    endtask

    task automatic drive(input int val, input int n);
        x = 16'(val);
        for (int i = 0; i < n; i++) begin
            if (toggle) enable = ~enable;
            tick();
            ntrig += int'(trigger);
            narm += int'(armed);
            yq.push_back(int'(y));
            if (act_vec !== exp_vec()) begin
                if (ndis == 0) begin first_got = act_vec; first_want = exp_vec(); end
                ndis++;
            end
        end
    endtask

    task automatic test_reset();
        config_dut(0, 100, 4, 8, 5);
        do_reset();
        clear_stats();
        drive(0, 5);
        drive(-1000, 10);
        nvec++;
        if (trig_count !== 16'd1) begin nerr++; $display("FAIL rst_pre_count: got %0d want 1", trig_count); end
        #2 reset = 1;
        mreset();
        #1;
        nvec++;
        if (act_vec !== '0) begin nerr++; $display("FAIL rst_async_outputs: got %h want 0", act_vec); end
        #2 reset = 0;
        clear_stats();
        drive(0, 50);
        nvec++;
        if (ntrig !== 0) begin nerr++; $display("FAIL rst_baseline_trig: got %0d want 0", ntrig); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL rst_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_negative_cfd();
        int nneg;
        config_dut(0, 100, 4, 8, 0);
        do_reset();
        drive(0, 10);
        clear_stats();
        drive(-1000, 30);
        nneg = 0;
        foreach (yq[i]) nneg += int'(yq[i] == -500);
        nvec++;
        if (nneg !== 4) begin nerr++; $display("FAIL neg_y_minus500: got %0d samples want 4", nneg); end
        nvec++;
        if (y !== 17'(500)) begin nerr++; $display("FAIL neg_y_final: got %0d want 500", y); end
        nvec++;
        if (ntrig !== 1) begin nerr++; $display("FAIL neg_pulses: got %0d want 1", ntrig); end
        nvec++;
        if (zc_pre !== 17'(-500)) begin nerr++; $display("FAIL neg_zc_pre: got %0d want -500", zc_pre); end
        nvec++;
        if (zc_post !== 17'(500)) begin nerr++; $display("FAIL neg_zc_post: got %0d want 500", zc_post); end
        nvec++;
        if (trig_count !== 16'd1) begin nerr++; $display("FAIL neg_trig_count: got %0d want 1", trig_count); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL neg_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_subthreshold();
        config_dut(0, 100, 4, 8, 0);
        do_reset();
        clear_stats();
        drive(0, 5);
        drive(-50, 40);
        nvec++;
        if (narm !== 0 || ntrig !== 0) begin nerr++; $display("FAIL sub_armed_trig: got armed %0d trig %0d want 0 0", narm, ntrig); end
        nvec++;
        if (trig_count !== 0 || timeout_count !== 0) begin nerr++; $display("FAIL sub_counters: got %0d %0d want 0 0", trig_count, timeout_count); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL sub_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_timeout();
        int c;
        config_dut(0, 100, 4, 0, 0);
        do_reset();
        clear_stats();
        for (int r = 1; r <= 3; r++) begin
            toggle = (r == 3);
            for (int i = 0; i < 10 && !armed; i++) drive(-1000, 1);
            c = 0;
            while (armed && c < 600) begin drive(-1000, 1); c++; end
            nvec++;
            if (c !== ((r == 3) ? 256 : 128)) begin nerr++; $display("FAIL timeout_len_%0d: got %0d clks want %0d", r, c, (r == 3) ? 256 : 128); end
            nvec++;
            if (timeout_count !== 16'(r)) begin nerr++; $display("FAIL timeout_count_%0d: got %0d want %0d", r, timeout_count, r); end
        end
        toggle = 0; enable = 1;
        nvec++;
        if (ntrig !== 0) begin nerr++; $display("FAIL timeout_trig: got %0d want 0", ntrig); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL timeout_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_holdoff();
        config_dut(0, 100, 4, 8, 20);
        do_reset();
        drive(0, 5);
        clear_stats();
        drive(-1000, 8); drive(0, 2); drive(-1000, 8); drive(0, 40);
        nvec++;
        if (ntrig !== 1) begin nerr++; $display("FAIL hold_10apart: got %0d triggers want 1", ntrig); end
        clear_stats();
        drive(-1000, 8); drive(0, 22); drive(-1000, 8); drive(0, 40);
        nvec++;
        if (ntrig !== 2) begin nerr++; $display("FAIL hold_30apart: got %0d triggers want 2", ntrig); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL hold_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_back_to_back();
        config_dut(0, 100, 4, 8, 0);
        do_reset();
        drive(0, 5);
        clear_stats();
        drive(-1000, 8); drive(0, 4); drive(-1000, 8); drive(0, 20);
        nvec++;
        if (ntrig !== 2) begin nerr++; $display("FAIL b2b_triggers: got %0d want 2", ntrig); end
        nvec++;
        if (trig_count !== 16'd2) begin nerr++; $display("FAIL b2b_count: got %0d want 2", trig_count); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL b2b_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_positive_clamp();
        int npos;
        config_dut(1, 100, 0, 31, 0);
        do_reset();
        drive(0, 5);
        clear_stats();
        drive(1000, 20);
        npos = 0;
        foreach (yq[i]) npos += int'(yq[i] == 1000);
        nvec++;
        if (npos !== 1) begin nerr++; $display("FAIL pos_y_1000: got %0d samples want 1", npos); end
        nvec++;
        if (y !== 17'(0)) begin nerr++; $display("FAIL pos_y_final: got %0d want 0", y); end
        nvec++;
        if (ntrig !== 1) begin nerr++; $display("FAIL pos_pulses: got %0d want 1", ntrig); end
        nvec++;
        if (zc_pre !== 17'(1000) || zc_post !== 17'(0)) begin nerr++; $display("FAIL pos_zc: got %0d %0d want 1000 0", zc_pre, zc_post); end
        nvec++;
        if (ndis !== 0) begin nerr++; $display("FAIL pos_model: %0d cycles off, got %h want %h", ndis, first_got, first_want); end
    endtask

    task automatic test_random();
        int plen, lvl;
        for (int seg = 0; seg < 6; seg++) begin
            config_dut(1'($urandom % 2), int'($urandom_range(0, 2000)), int'($urandom % 32),
                       int'($urandom % 32), int'($urandom_range(0, 40)));
            do_reset();
            plen = 0; lvl = 0;
            for (int i = 0; i < 400; i++) begin
                if (plen == 0) begin
                    plen = int'($urandom_range(1, 40));
                    lvl  = ($urandom % 3 == 0) ? 0 : int'($urandom_range(0, 5000));
                    if ((polarity == 0) != ($urandom % 5 == 0)) lvl = -lvl;
                end
                plen--;
                x = 16'(lvl);
                enable = ($urandom % 4) != 0;
                if ($urandom % 50 == 0) holdoff = 16'($urandom_range(0, 40));
                if ($urandom % 80 == 0) threshold = 16'($urandom_range(0, 2000));
                tick();
                nvec++;
                if (act_vec !== exp_vec()) begin
                    nerr++;
                    $display("FAIL rand_seg%0d_cyc%0d: got %h want %h", seg, i, act_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_negative_cfd();
        test_subthreshold();
        test_timeout();
        test_holdoff();
        test_back_to_back();
        test_positive_clamp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cfd_selftrigger_multimode.md
Name: cfd_selftrigger_multimode

Overview:
Parametrised constant-fraction self-trigger for one DAPHNE channel. It adds runtime-programmable delay, attenuation fraction, pulse polarity, arm timeout and post-trigger holdoff. It also latches the two samples bracketing the zero crossing so downstream logic can interpolate sub-sample timing. It sits between the pedestal-recovery filter output and the spy/self-trigger logic.

Parameters:
- DATA_W, 16, signed sample width.
- MAX_DELAY, 32, delay-line depth; power of 2; DLY_W = log2(MAX_DELAY).
- FRAC_W, 4, fraction resolution; fraction = frac_num / 2^FRAC_W.
- ARM_TIMEOUT, 128, enabled cycles allowed in ARMED before giving up.
- HOLD_W, 16, holdoff counter width.
- CNT_W, 16, status counter width.

Ports:
- clk  in  1  sample clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  sample-valid/advance strobe.
- x  in  DATA_W  signed input sample.
- threshold  in  DATA_W  signed magnitude; only values >= 0 are valid.
- polarity  in  1  0 = negative-going pulses, 1 = positive-going.
- delay  in  DLY_W  CFD delay in samples; 0 is treated as 1.
- frac_num  in  FRAC_W+1  fraction numerator; values above 2^FRAC_W clamp to 2^FRAC_W.
- holdoff  in  HOLD_W  dead time after a trigger, in clk cycles.
- trigger  out  1  one-cycle pulse.
- y  out  DATA_W+1  signed CFD output (y_1).
- zc_pre, zc_post  out  DATA_W+1  y_2 and y_1 latched at trigger.
- armed  out  1  high in ARMED.
- trig_count, timeout_count  out  CNT_W  saturating counters.

Behaviour:
- Reset (async): all registers 0, FSM in IDLE, delay-line read data treated as 0. All outputs are 0.
- Datapath; each register advances only when enable=1:
  - in_reg <= x.
  - d = in_reg delayed by `delay` enabled cycles (sub-module).
  - y_1 <= ((in_reg * frac_c) >>> FRAC_W) - d, with full precision into DATA_W+1 bits and arithmetic shift.
  - y_2 <= y_1.
- Latency: x to y is 2 enabled cycles for the prompt term and delay+2 for the delayed term.
- Crossing (xc):
  - polarity=0: y_2 < 0 and y_1 >= 0.
  - polarity=1: y_2 > 0 and y_1 <= 0.
- Threshold hit (th):
  - polarity=0: in_reg < -threshold.
  - polarity=1: in_reg > threshold.
  - Comparison is done in DATA_W+1 bits.
- FSM states: IDLE, ARMED, FIRE, HOLDOFF.
  - IDLE: on enable and th, go to ARMED and clear arm_cnt.
  - ARMED: on enable and xc, go to FIRE. Otherwise, on enable, arm_cnt increments; when arm_cnt = ARM_TIMEOUT-1, go to IDLE and increment timeout_count. xc takes priority over timeout in the same cycle. When enable=0 the state holds.
  - FIRE: lasts exactly one clk cycle regardless of enable. trigger=1 (registered output, high while in FIRE). Latch zc_pre<=y_2 and zc_post<=y_1 on entry. Increment trig_count. Load hold_cnt<=holdoff. Next state is HOLDOFF, or IDLE if holdoff=0.
  - HOLDOFF: hold_cnt decrements every clk cycle (independent of enable); at 1, go to IDLE. th and xc are ignored.
- Counters saturate at all-ones; no wrap.
- Config inputs are sampled every cycle with no shadowing:
  - A delay change takes effect immediately; y is undefined for MAX_DELAY enabled cycles afterwards.
  - A holdoff change affects only the next load.
- Reset asserted in any state: trigger drops asynchronously, FSM returns to IDLE, and latched values and counters clear.
- Simultaneous th and xc in IDLE: only ARMED is entered; FIRE requires an xc seen while ARMED.

Decomposition:
- Package cfd_pkg holds:
  - state encoding (IDLE/ARMED/FIRE/HOLDOFF);
  - function clamp_frac;
  - constant DLY_W derivation.
- Sub-module cfd_delay_line (DATA_W, MAX_DELAY):
  - circular buffer of MAX_DELAY entries;
  - write pointer advances on enable;
  - read address = wr_ptr - delay, modulo MAX_DELAY;
  - synchronous read, aligned so that delay=N yields in_reg from N enabled cycles earlier;
  - maps to distributed RAM/SRL.

Test Plan:
- Reset: assert reset mid-stream with x=-1000 -> trigger, y, zc_*, counters all 0 and armed=0 on the same cycle; deassert and run baseline 0 for 50 cycles -> no trigger.
- Negative CFD: polarity=0, threshold=100, delay=4, frac_num=8, enable=1, step x 0 -> -1000 held -> y=-500 for 4 samples, then +500; exactly one trigger pulse; zc_pre=-500, zc_post=500, trig_count=1.
- Sub-threshold: same config, step to -50 -> armed never asserts, trigger=0, counters 0.
- Timeout: frac_num=0, step x to -1000 -> y never < 0, no trigger; armed for 128 enabled cycles then drops; timeout_count=1 (2 after 256 cycles); toggle enable 50% -> timeout takes 256 clks.
- Holdoff: holdoff=20, config as scenario 2, two pulses 10 cycles apart -> one trigger; 30 cycles apart -> two triggers; holdoff=0 -> back-to-back pulses each trigger.
- Positive polarity and clamp: polarity=1, step to +1000, frac_num=31 (clamped to 16), delay=0 (treated as 1) -> y=+1000 for one sample then 0; trigger once, zc_pre=1000, zc_post=0.
